// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if -- signal bundle between the fetch stage and its surroundings.
//
// Carries the pipeline control inputs (stall, redirect, redirect_pc), the
// instruction ROM port (rom_addr out, rom_inst back in) and the IF/ID
// register outputs handed to decode (if_inst, if_pc, if_pc4, if_valid).
//
// Modports:
//   slave  : the fetch stage itself (drives rom_addr and the IF/ID outputs)
//   master : the environment (control logic, ROM, decode)
// ---------------------------------------------------------------------------
interface if_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic        if_valid;

   modport slave (
      input  stall, redirect, redirect_pc, rom_inst,
      output rom_addr, if_inst, if_pc, if_pc4, if_valid
   );

   modport master (
      output stall, redirect, redirect_pc, rom_inst,
      input  rom_addr, if_inst, if_pc, if_pc4, if_valid
   );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with PC register and IF/ID register.
//
// The PC drives the instruction ROM address directly; the ROM answers in the
// same cycle, and the instruction is captured into the IF/ID register on the
// next rising clock edge. Per cycle, redirect beats stall, which beats a normal
// fetch. A redirect loads the word-aligned target into the PC and puts a
// bubble (NOP_INST, if_valid = 0) into IF/ID, which costs one cycle.
//
// Parameters:
//   RESET_PC  PC value loaded by reset
//   NOP_INST  bubble instruction placed in IF/ID on reset or flush
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   rst         asynchronous active-high reset
//   bus         if_stage_if.slave (stall, redirect, redirect_pc, rom_addr,
//               rom_inst, if_inst, if_pc, if_pc4, if_valid)
//   fetch_cnt   (IF_PERF_CNT_EN only) number of normal fetch cycles
//   flush_cnt   (IF_PERF_CNT_EN only) number of redirect cycles
//
// Configuration macro: IF_PERF_CNT_EN adds the two wrapping 32-bit
// performance counters and their output ports.
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP_INST = 32'hffffffff
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.slave   bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt
`endif
);

   logic [31:0] pc_q,    pc_d;
   logic [31:0] inst_q,  inst_d;
   logic [31:0] ifpc_q,  ifpc_d;
   logic [31:0] ifpc4_q, ifpc4_d;
   logic        valid_q, valid_d;
   logic [31:0] pcPlus4;

   // PC + 4 wraps naturally at 2^32 and carries no flag.
   assign pcPlus4 = pc_q + 32'd4;

   // Next-state selection: redirect, then stall, then normal fetch.
   // A redirect keeps if_pc/if_pc4 from the last real fetch.
   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      ifpc_d  = ifpc_q;
      ifpc4_d = ifpc4_q;
      valid_d = valid_q;
      if (bus.redirect) begin
         pc_d    = {bus.redirect_pc[31:2], 2'b00};
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else if (!bus.stall) begin
         pc_d    = pcPlus4;
         inst_d  = bus.rom_inst;
         ifpc_d  = pc_q;
         ifpc4_d = pcPlus4;
         valid_d = 1'b1;
      end
   end

   // PC and IF/ID registers; reset acts immediately and discards any
   // stall or redirect in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         ifpc_q  <= 32'd0;
         ifpc4_q <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ifpc_q  <= ifpc_d;
         ifpc4_q <= ifpc4_d;
         valid_q <= valid_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetchCnt_q, flushCnt_q;

   // Count normal fetches and redirect cycles; stall cycles count as neither.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetchCnt_q <= 32'd0;
         flushCnt_q <= 32'd0;
      end else if (bus.redirect) begin
         flushCnt_q <= flushCnt_q + 32'd1;
      end else if (!bus.stall) begin
         fetchCnt_q <= fetchCnt_q + 32'd1;
      end
   end

   assign fetch_cnt = fetchCnt_q;
   assign flush_cnt = flushCnt_q;
`endif

   assign bus.rom_addr = pc_q;
   assign bus.if_inst  = inst_q;
   assign bus.if_pc    = ifpc_q;
   assign bus.if_pc4   = ifpc4_q;
   assign bus.if_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
//
// The ROM model answers rom_inst = {rom_addr[15:0], 16'hA5A5}, or NOP_INST
// while romNop is set. Inputs change 1 time unit after a rising edge, and
// outputs are checked at that same point, after the edge has settled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_stage;

   logic clk;
   logic rst;
   logic romNop;
   int   total;
   int   bad;

   if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetchCnt;
   logic [31:0] flushCnt;
`endif

   if_stage #(
      .RESET_PC (32'h00000000),
      .NOP_INST (32'hffffffff)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt (fetchCnt),
      .flush_cnt (flushCnt)
`endif
   );

   // Zero-latency ROM model.
   assign bus.rom_inst = romNop ? 32'hffffffff : {bus.rom_addr[15:0], 16'hA5A5};

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Set the control inputs just after an edge, then advance to 1 ns past
   // the next rising edge.
   task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp);
      bus.stall       = s;
      bus.redirect    = r;
      bus.redirect_pc = rp;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare the whole IF/ID register plus rom_addr at once.
   task automatic checkAll(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                           input logic [31:0] pc, input logic [31:0] pc4, input logic vld);
      checkOutput({tag, ".rom_addr"}, bus.rom_addr, addr);
      checkOutput({tag, ".if_inst"},  bus.if_inst,  inst);
      checkOutput({tag, ".if_pc"},    bus.if_pc,    pc);
      checkOutput({tag, ".if_pc4"},   bus.if_pc4,   pc4);
      checkOutput({tag, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, vld});
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      romNop = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      rst = 1'b1;
      #3;
      checkAll("reset", 32'h0, 32'hffffffff, 32'h0, 32'h0, 1'b0);

      // Release reset with stall high: first edge must not fetch.
      bus.stall = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("rel_stall", 32'h0, 32'hffffffff, 32'h0, 32'h0, 1'b0);

      // Three free fetches.
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("fetch0", 32'h4, 32'h0000A5A5, 32'h0, 32'h4, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("fetch1", 32'h8, 32'h0004A5A5, 32'h4, 32'h8, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("fetch2", 32'hC, 32'h0008A5A5, 32'h8, 32'hC, 1'b1);

      // Two stall cycles at PC = 0x0C, then release.
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("stall0", 32'hC, 32'h0008A5A5, 32'h8, 32'hC, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkAll("stall1", 32'hC, 32'h0008A5A5, 32'h8, 32'hC, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("unstall", 32'h10, 32'h000CA5A5, 32'hC, 32'h10, 1'b1);

      // Redirect to an unaligned target: aligned PC, one bubble.
      applyStimulus(1'b0, 1'b1, 32'h23);
      checkAll("redir", 32'h20, 32'hffffffff, 32'hC, 32'h10, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("redir_next", 32'h24, 32'h0020A5A5, 32'h20, 32'h24, 1'b1);

      // Redirect and stall together: redirect wins.
      applyStimulus(1'b1, 1'b1, 32'h40);
      checkAll("redir_stall", 32'h40, 32'hffffffff, 32'h20, 32'h24, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("rs_next", 32'h44, 32'h0040A5A5, 32'h40, 32'h44, 1'b1);

      // Wrap at the top of the address space.
      applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC);
      checkOutput("wrap.redir_pc", bus.rom_addr, 32'hFFFFFFFC);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("wrap0", 32'h0, 32'hFFFCA5A5, 32'hFFFFFFFC, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("wrap1", 32'h4, 32'h0000A5A5, 32'h0, 32'h4, 1'b1);

      // 0xFC -> 0x100 is a plain increment.
      applyStimulus(1'b0, 1'b1, 32'hFC);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("cross", 32'h100, 32'h00FCA5A5, 32'hFC, 32'h100, 1'b1);

      // A NOP_INST read from the ROM is a valid instruction.
      romNop = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("sw_nop", 32'h104, 32'hffffffff, 32'h100, 32'h104, 1'b1);
      romNop = 1'b0;

      // Reset mid-run while stall and redirect are both active.
      bus.stall       = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h80;
      #2;
      rst = 1'b1;
      #1;
      checkAll("mid_rst", 32'h0, 32'hffffffff, 32'h0, 32'h0, 1'b0);
      bus.stall    = 1'b0;
      bus.redirect = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("post_rst0", 32'h4, 32'h0000A5A5, 32'h0, 32'h4, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("post_rst1", 32'h8, 32'h0004A5A5, 32'h4, 32'h8, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAll("post_rst2", 32'hC, 32'h0008A5A5, 32'h8, 32'hC, 1'b1);

`ifdef IF_PERF_CNT_EN
      // Counters: 5 fetches, 1 redirect, 2 stalls after a fresh reset.
      rst = 1'b1;
      #1;
      checkOutput("cnt_rst.fetch", fetchCnt, 32'd0);
      checkOutput("cnt_rst.flush", flushCnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h30);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      bus.stall = 1'b0;
      checkOutput("cnt.fetch", fetchCnt, 32'd5);
      checkOutput("cnt.flush", flushCnt, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
